// File: rtl/ram_sad_scheduler.sv
// Write-port arbiter and lock-step SAD sequencer for the paired ref/act 16x25-bit RAMs.
// Optional early-exit threshold compare is enabled by defining SAD_EARLY_EXIT_EN.
module ram_sad_scheduler #(
    parameter int DW    = 25,
    parameter int AW    = 11,
    parameter int DEPTH = 16,
    parameter int SW    = 29
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic          ld_sel,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          start,
    input  logic [4:0]    len,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] sad,
`ifdef SAD_EARLY_EXIT_EN
    input  logic [SW-1:0] thresh,
    output logic          early,
`endif
    output logic [AW-1:0] ref_addr_rd,
    output logic [AW-1:0] act_addr_rd,
    output logic [AW-1:0] ref_addr_wr,
    output logic [AW-1:0] act_addr_wr,
    output logic [DW-1:0] ref_in,
    output logic [DW-1:0] act_in,
    output logic          ref_wr_enm,
    output logic          act_wr_enm,
    input  logic [DW-1:0] ref_out,
    input  logic [DW-1:0] act_out
);

    localparam int         IW      = $clog2(DEPTH);
    localparam logic [4:0] LEN_MAX = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [4:0]      n_r;
    logic [4:0]      index_r;
    logic [DW-1:0]   pipe_d_r;
    logic            pipe_v_r;
    logic [SW-1:0]   acc_r;
    logic [SW-1:0]   sad_r;
    logic            busy_r;
    logic            done_r;
    logic            early_r;
    logic [SW-1:0]   acc_next_s;
    logic [DW-1:0]   diff_s;
    logic [4:0]      n_clamp_s;
    logic            start_accept_s;
    logic            ld_ready_s;
    logic            early_hit_s;
`ifdef SAD_EARLY_EXIT_EN
    logic [SW-1:0]   thresh_r;
`endif

    function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    assign start_accept_s = (state_r == S_IDLE) && start && !rst;
    assign ld_ready_s     = (state_r == S_IDLE) && !start && !rst;
    assign n_clamp_s      = (len > LEN_MAX) ? LEN_MAX : len;
    assign diff_s         = abs_diff(ref_out, act_out);
    assign acc_next_s     = acc_r + (pipe_v_r ? {{(SW-DW){1'b0}}, pipe_d_r} : {SW{1'b0}});

    // Early-exit detection after an accumulate.
    always_comb begin
        early_hit_s = 1'b0;
`ifdef SAD_EARLY_EXIT_EN
        if (((state_r == S_RUN) || (state_r == S_FLUSH)) && pipe_v_r && (acc_next_s > thresh_r)) begin
            early_hit_s = 1'b1;
        end else begin
            early_hit_s = 1'b0;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_accept_s) begin
                    state_next_s = (n_clamp_s == 5'd0) ? S_DONE : S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (early_hit_s) begin
                    state_next_s = S_DONE;
                end else if (index_r == (n_r - 5'd1)) begin
                    state_next_s = S_FLUSH;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_FLUSH: state_next_s = S_DONE;
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, pipeline, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            n_r      <= 5'd0;
            index_r  <= 5'd0;
            pipe_d_r <= {DW{1'b0}};
            pipe_v_r <= 1'b0;
            acc_r    <= {SW{1'b0}};
            sad_r    <= {SW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            early_r  <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
            thresh_r <= {SW{1'b0}};
`endif
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == S_RUN) || (state_next_s == S_FLUSH);
            done_r  <= (state_next_s == S_DONE);
            if (start_accept_s) begin
                n_r      <= n_clamp_s;
                index_r  <= 5'd0;
                acc_r    <= {SW{1'b0}};
                pipe_v_r <= 1'b0;
                early_r  <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
                thresh_r <= thresh;
`endif
            end else if (state_r == S_RUN) begin
                index_r  <= index_r + 5'd1;
                pipe_d_r <= diff_s;
                pipe_v_r <= 1'b1;
                acc_r    <= acc_next_s;
            end else if (state_r == S_FLUSH) begin
                pipe_v_r <= 1'b0;
                acc_r    <= acc_next_s;
            end else begin
                pipe_v_r <= 1'b0;
            end
            // The final pipe entry is folded in on the same edge that enters DONE.
            if (state_next_s == S_DONE && state_r != S_DONE) begin
                sad_r   <= (state_r == S_IDLE) ? {SW{1'b0}} : acc_next_s;
                early_r <= early_hit_s;
            end else begin
                sad_r   <= sad_r;
            end
        end
    end

    // Host write steering; only the selected RAM sees the address, data and enable.
    always_comb begin
        ref_addr_wr = {AW{1'b0}};
        act_addr_wr = {AW{1'b0}};
        ref_in      = {DW{1'b0}};
        act_in      = {DW{1'b0}};
        ref_wr_enm  = 1'b0;
        act_wr_enm  = 1'b0;
        if (ld_valid && ld_ready_s) begin
            if (ld_sel == 1'b0) begin
                ref_addr_wr = ld_addr;
                ref_in      = ld_data;
                ref_wr_enm  = 1'b1;
            end else begin
                act_addr_wr = ld_addr;
                act_in      = ld_data;
                act_wr_enm  = 1'b1;
            end
        end else begin
            ref_wr_enm  = 1'b0;
            act_wr_enm  = 1'b0;
        end
    end

    assign ref_addr_rd = (!rst && state_r == S_RUN) ? {{(AW-IW){1'b0}}, index_r[IW-1:0]} : {AW{1'b0}};
    assign act_addr_rd = ref_addr_rd;
    assign ld_ready    = ld_ready_s;
    assign busy        = busy_r;
    assign done        = done_r;
    assign sad         = sad_r;
`ifdef SAD_EARLY_EXIT_EN
    assign early       = early_r;
`endif

endmodule

// File: tb/tb_ram_sad_scheduler.sv
// Directed bench for ram_sad_scheduler with behavioural models of both RAMs.
module tb_ram_sad_scheduler;
    localparam int DW = 25;
    localparam int AW = 11;
    localparam int SW = 29;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic          ld_sel;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          start;
    logic [4:0]    len;
    logic          busy;
    logic          done;
    logic [SW-1:0] sad;
`ifdef SAD_EARLY_EXIT_EN
    logic [SW-1:0] thresh;
    logic          early;
`endif
    logic [AW-1:0] ref_addr_rd, act_addr_rd, ref_addr_wr, act_addr_wr;
    logic [DW-1:0] ref_in, act_in, ref_out, act_out;
    logic          ref_wr_enm, act_wr_enm;

    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] act_mem [16];

    int n_cmp = 0;
    int n_err = 0;

    ram_sad_scheduler dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .start(start), .len(len), .busy(busy), .done(done), .sad(sad),
`ifdef SAD_EARLY_EXIT_EN
        .thresh(thresh), .early(early),
`endif
        .ref_addr_rd(ref_addr_rd), .act_addr_rd(act_addr_rd),
        .ref_addr_wr(ref_addr_wr), .act_addr_wr(act_addr_wr),
        .ref_in(ref_in), .act_in(act_in),
        .ref_wr_enm(ref_wr_enm), .act_wr_enm(act_wr_enm),
        .ref_out(ref_out), .act_out(act_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ref_wr_enm) ref_mem[ref_addr_wr[3:0]] <= ref_in;
        if (act_wr_enm) act_mem[act_addr_wr[3:0]] <= act_in;
    end
    assign ref_out = ref_mem[ref_addr_rd[3:0]];
    assign act_out = act_mem[act_addr_rd[3:0]];

    typedef struct {
        string        name;
        logic [4:0]   len;
        logic [SW-1:0] exp_sad;
        int           exp_lat;
        int           exp_busy;
    } pass_vec_t;

    pass_vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = {7'd0, addr};
        ld_data  = data;
        #1;
        check("load_ready", 64'(ld_ready), 64'd1);
        check("load_wen", 64'({ref_wr_enm, act_wr_enm}), sel ? 64'd1 : 64'd2);
        step();
        ld_valid = 1'b0;
    endtask

    // Starts a pass, pokes start mid-pass, and checks latency, result, busy width and write stalling.
    task automatic run_pass(input string nm, input logic [4:0] l, input logic [SW-1:0] exp_sad,
                            input int exp_lat, input int exp_busy);
        int k = 0;
        int busy_cnt = 0;
        bit seen = 1'b0;
        bit stall_ok = 1'b1;
        start = 1'b1;
        len   = l;
        #1;
        check({nm, "_start_ready"}, 64'(ld_ready), 64'd0);
        while (!seen && k < 40) begin
            step();
            k++;
            if (ld_ready !== 1'b0 || ref_wr_enm !== 1'b0 || act_wr_enm !== 1'b0) stall_ok = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) seen = 1'b1;
            start = (k == 2) && !seen;
            len   = 5'd3;
        end
        start = 1'b0;
        if (!seen) begin
            check({nm, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({nm, "_lat"}, 64'(k), 64'(exp_lat));
            check({nm, "_sad"}, 64'(sad), 64'(exp_sad));
            check({nm, "_busy"}, 64'(busy_cnt), 64'(exp_busy));
            check({nm, "_stall"}, 64'(stall_ok), 64'd1);
            step();
            check({nm, "_pulse"}, 64'({done, busy, ld_ready}), 64'd1);
        end
    endtask

    initial begin
        vecs[0] = '{"len16", 5'd16, 29'd120, 18, 17};
        vecs[1] = '{"len20", 5'd20, 29'd120, 18, 17};
        vecs[2] = '{"len0",  5'd0,  29'd0,   1,  0};
        vecs[3] = '{"len1",  5'd1,  29'd0,   3,  2};
        vecs[4] = '{"len4",  5'd4,  29'd6,   6,  5};
        vecs[5] = '{"len7",  5'd7,  29'd21,  9,  8};

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 25'd0;
            act_mem[i] = 25'd0;
        end
        rst = 1'b1; start = 1'b0; len = 5'd0;
        ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 11'h7; ld_data = 25'h1AB;
`ifdef SAD_EARLY_EXIT_EN
        thresh = {SW{1'b1}};
`endif
        step();
        step();
        check("rst_ready", 64'(ld_ready), 64'd0);
        check("rst_wen", 64'({ref_wr_enm, act_wr_enm}), 64'd0);
        check("rst_addr", 64'({ref_addr_wr, act_addr_wr, ref_addr_rd, act_addr_rd}), 64'd0);
        check("rst_regs", 64'({busy, done, sad}), 64'd0);
        rst = 1'b0;
        ld_valid = 1'b0;
        #1;
        check("idle_ready", 64'(ld_ready), 64'd1);

        for (int i = 0; i < 16; i++) load(1'b0, 4'(i), 25'(i));
        for (int i = 0; i < 16; i++) load(1'b1, 4'(i), 25'd0);

        for (int v = 0; v < 6; v++)
            run_pass(vecs[v].name, vecs[v].len, vecs[v].exp_sad, vecs[v].exp_lat, vecs[v].exp_busy);

        // Full-scale difference on a single word.
        load(1'b0, 4'd0, 25'h0000005);
        load(1'b1, 4'd0, 25'h1FFFFFF);
        run_pass("maxdiff", 5'd1, 29'h1FFFFFA, 3, 2);

        // Load held across a pass and alongside start: it must land in the first IDLE cycle.
        ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 11'h5; ld_data = 25'h123;
        run_pass("stall", 5'd4, 29'h2000000, 6, 5);
        check("stall_wr_en", 64'({ref_wr_enm, act_wr_enm}), 64'd1);
        check("stall_wr_addr", 64'(act_addr_wr), 64'h5);
        check("stall_wr_data", 64'(act_in), 64'h123);
        step();
        ld_valid = 1'b0;
        run_pass("after_stall", 5'd16, 29'h200018B, 18, 17);

        // Reset in the fifth cycle of a full pass.
        start = 1'b1; len = 5'd16;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 11'h3; ld_data = 25'h1555;
        #1;
        check("abort_wen", 64'({ref_wr_enm, act_wr_enm}), 64'd0);
        check("abort_addr", 64'({ref_addr_wr, ref_addr_rd, act_addr_rd}), 64'd0);
        step();
        rst = 1'b0;
        ld_valid = 1'b0;
        check("abort_regs", 64'({busy, done, sad}), 64'd0);
        begin
            bit no_done = 1'b1;
            for (int i = 0; i < 20; i++) begin
                step();
                if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
            end
            check("abort_no_done", 64'(no_done), 64'd1);
        end
        run_pass("post_abort", 5'd16, 29'h200018B, 18, 17);

`ifdef SAD_EARLY_EXIT_EN
        for (int i = 0; i < 16; i++) load(1'b0, 4'(i), 25'd4);
        for (int i = 0; i < 16; i++) load(1'b1, 4'(i), 25'd0);
        thresh = 29'd10;
        run_pass("early", 5'd16, 29'd12, 5, 4);
        check("early_flag", 64'(early), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
